puf2usrp: RTL and testbench
===========================

# puf2usrp

Streaming 5:4 fractional decimator for packed IQ samples. It sits on the receive side, between the PUF-rate sample domain and the USRP-rate datapath, and reverses the 4:5 linear-interpolating upsampler on the transmit side. Every group of 5 input samples yields 4 output samples, computed by two-tap linear interpolation with Q15 weights. Both sides use AXI-Stream handshakes with full backpressure.

## Interface
- DATA_WIDTH, 16, bits per I or Q component (signed two's complement)
- clk  in  1  single clock; all logic is on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_tvalid  in  1  input beat valid
- in_tready  out  1  input beat accepted when in_tvalid && in_tready
- in_tlast  in  1  last beat of input packet
- in_tdata  in  2*DATA_WIDTH  I in [2W-1:W], Q in [W-1:0]
- out_tvalid  out  1  output beat valid
- out_tready  in  1  downstream ready
- out_tlast  out  1  last beat of output packet
- out_tdata  out  2*DATA_WIDTH  same packing as in_tdata

## Operation
- Phase counter p in 0..4 counts accepted input beats. The current beat is x, and prev is the previous accepted beat of the same packet.
- Per-component output for each phase, with the weight on prev listed first:
  - p=0: output x unchanged (exact passthrough, no multiply error).
  - p=1: no output; x is stored into prev.
  - p=2: 24576·prev + 8192·x
  - p=3: 16384·prev + 16384·x
  - p=4: 8192·prev + 24576·x
- Every accepted beat loads prev with x. p advances 4→0.
- Arithmetic is per I and Q:
  - signed W × unsigned 16-bit weight gives a (W+17)-bit signed product;
  - sum both taps, add 2^14, arithmetic shift right by 15 (round half toward +inf);
  - saturate to [−2^(W−1), 2^(W−1)−1].
- in_tvalid gaps do not change p or prev.
- tlast handling:
  - When an accepted beat has in_tlast=1, the output it produces carries out_tlast=1.
  - A tlast beat at p=1 does not drop: it emits x as a passthrough output with out_tlast=1.
  - After any tlast beat, p is set to 0 and prev to 0.
- Reset (reset_n low, asynchronous):
  - p=0, prev=0, all pipeline valids=0;
  - out_tvalid=0, out_tlast=0, out_tdata=0;
  - in_tready=0 while reset_n is low;
  - in-flight samples are discarded;
  - the first beat after release is p=0.

## Timing
- Two-stage pipeline:
  - S1 registers the products, tlast, and an output-valid flag (0 for a non-tlast p=1 beat);
  - S2 registers sum, round, saturate, and drives out_*.
- Latency is 2 cycles from an accepted input beat to out_tvalid for the corresponding output.
- Stall condition is stall = out_tvalid && !out_tready. When stalled:
  - the whole pipeline freezes;
  - in_tready=0 (combinational);
  - out_tdata and out_tlast hold stable.
- in_tready = !stall && reset_n. Bubbles (a p=1 beat or idle input) do not cause a stall.
- Throughput: with out_tready=1 continuously, 1 input per cycle and 4 outputs per 5 cycles; no dead cycles.
- p=1 and the S2 output transfer can occur in the same cycle. out_tready may toggle every cycle with no loss or duplication.

## Test plan
- Ramp, out_tready=1:
  - Stimulus: I = 0,100,…,900 and Q = −I, back-to-back.
  - Required: outputs I = 0,125,250,375,500,625,750,875 and Q negated; first out_tvalid 2 cycles after the first accept; exactly 8 outputs.
- Rounding:
  - Stimulus: group x = 0,1,2,0,0 (I=Q).
  - Required: p2 = 0.75·1+0.25·2 = 1.25 → 1; p3 = 0.5·2 = 1.
  - Stimulus: group 0,−1,−2,0,0.
  - Required: p2 → −1; p3 = −1.0 → −1.
  - Stimulus: p3 with prev=1, x=2.
  - Required: 1.5 → 2.
  - Stimulus: p3 with prev=−1, x=−2.
  - Required: −1.5 → −1.
- Backpressure:
  - Stimulus: 20-beat ramp with out_tready low for 5 cycles mid-stream and random toggling afterwards.
  - Required: in_tready=0 exactly while stalled; held out_tdata unchanged; output sequence identical to the unstalled run.
- tlast at p=1:
  - Stimulus: packet {10, 20(tlast)}, then packet 0,100,200,300,400.
  - Required: outputs 10, 20(tlast=1), 0, 125, 250, 375(tlast=0), with the phase restarted at 0.
- Saturation extremes:
  - Stimulus: I = 32767 for 5 beats, Q = −32768 for 5 beats.
  - Required: all outputs I = 32767, Q = −32768; no wrap.
- Async reset mid-stream:
  - Stimulus: assert reset_n=0 between clock edges with 2 outputs in flight.
  - Required: out_tvalid, out_tlast and out_tdata go to 0 immediately; no stale outputs after release; the next input is treated as p=0 passthrough.

Source files
------------

// File: rtl/puf2usrp.sv
// 5:4 fractional decimator for packed IQ samples. Each group of five accepted input beats
// produces four outputs by two-tap linear interpolation with Q15 weights. Two-stage pipeline:
// S1 holds the tap products, S2 holds the rounded and saturated result driving out_*.
module puf2usrp #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_tvalid,
    output logic                    in_tready,
    input  logic                    in_tlast,
    input  logic [2*DATA_WIDTH-1:0] in_tdata,
    output logic                    out_tvalid,
    input  logic                    out_tready,
    output logic                    out_tlast,
    output logic [2*DATA_WIDTH-1:0] out_tdata
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned PW = W + 17;  // signed sample x unsigned 16-bit weight
    localparam int unsigned SW = W + 18;  // sum of two products

    localparam int RoundBias = 16384;
    localparam logic signed [SW-1:0] SatMax = SW'(2 ** (W - 1) - 1);
    localparam logic signed [SW-1:0] SatMin = -SatMax - SW'(1);

    // Weight pair that reproduces x exactly after the >>15.
    localparam logic [15:0] WPass = 16'd32768;

    typedef enum logic [2:0] {Ph0, Ph1, Ph2, Ph3, Ph4} phase_e;

    function automatic logic signed [PW-1:0] mul_w(input logic signed [W-1:0] a,
                                                   input logic [15:0] w);
        return PW'(a) * $signed(PW'(w));
    endfunction

    // Sum both taps, round half toward +inf, then clamp to the output range.
    function automatic logic [W-1:0] round_sat(input logic signed [PW-1:0] a,
                                               input logic signed [PW-1:0] b);
        logic signed [SW-1:0] sum;
        sum = SW'(a) + SW'(b) + SW'(RoundBias);
        sum = sum >>> 15;
        if (sum > SatMax) begin
            return SatMax[W-1:0];
        end else if (sum < SatMin) begin
            return SatMin[W-1:0];
        end
        return sum[W-1:0];
    endfunction

    phase_e         phase_q, phase_d;
    logic [2*W-1:0] prev_q, prev_d;

    logic                 s1_valid_q, s1_last_q;
    logic signed [PW-1:0] s1_re_prev_q, s1_re_x_q, s1_im_prev_q, s1_im_x_q;

    logic           out_valid_q, out_last_q;
    logic [2*W-1:0] out_data_q;

    logic stall, accept, emit;
    logic [15:0] w_prev, w_x;
    logic signed [W-1:0] x_re, x_im, prev_re, prev_im;

    assign x_re    = in_tdata[2*W-1:W];
    assign x_im    = in_tdata[W-1:0];
    assign prev_re = prev_q[2*W-1:W];
    assign prev_im = prev_q[W-1:0];

    assign stall     = out_valid_q && !out_tready;
    assign in_tready = !stall && reset_n;
    assign accept    = in_tvalid && in_tready;
    // Phase 1 only stores prev, unless it closes the packet.
    assign emit      = (phase_q != Ph1) || in_tlast;

    assign out_tvalid = out_valid_q;
    assign out_tlast  = out_last_q;
    assign out_tdata  = out_data_q;

    // Interpolation weights for the current phase (prev tap, x tap).
    always_comb begin
        w_prev = 16'd0;
        w_x    = WPass;
        case (phase_q)
            Ph2: begin
                w_prev = 16'd24576;
                w_x    = 16'd8192;
            end
            Ph3: begin
                w_prev = 16'd16384;
                w_x    = 16'd16384;
            end
            Ph4: begin
                w_prev = 16'd8192;
                w_x    = 16'd24576;
            end
            default: begin
                w_prev = 16'd0;
                w_x    = WPass;
            end
        endcase
    end

    // Next phase and prev sample; tlast restarts the group with a zero history.
    always_comb begin
        phase_d = phase_q;
        prev_d  = prev_q;
        if (accept) begin
            if (in_tlast) begin
                phase_d = Ph0;
                prev_d  = '0;
            end else begin
                prev_d = in_tdata;
                case (phase_q)
                    Ph0:     phase_d = Ph1;
                    Ph1:     phase_d = Ph2;
                    Ph2:     phase_d = Ph3;
                    Ph3:     phase_d = Ph4;
                    default: phase_d = Ph0;
                endcase
            end
        end
    end

    // Phase and prev state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= Ph0;
            prev_q  <= '0;
        end else begin
            phase_q <= phase_d;
            prev_q  <= prev_d;
        end
    end

    // S1: register tap products and output flags; frozen while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_re_prev_q <= '0;
            s1_re_x_q    <= '0;
            s1_im_prev_q <= '0;
            s1_im_x_q    <= '0;
        end else if (!stall) begin
            s1_valid_q <= accept && emit;
            s1_last_q  <= accept && in_tlast;
            if (accept) begin
                s1_re_prev_q <= mul_w(prev_re, w_prev);
                s1_re_x_q    <= mul_w(x_re, w_x);
                s1_im_prev_q <= mul_w(prev_im, w_prev);
                s1_im_x_q    <= mul_w(x_im, w_x);
            end
        end
    end

    // S2: sum, round and saturate into the output register; data and last hold while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else if (!stall) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_last_q <= s1_last_q;
                out_data_q <= {round_sat(s1_re_prev_q, s1_re_x_q),
                               round_sat(s1_im_prev_q, s1_im_x_q)};
            end
        end
    end

endmodule

// File: tb/tb_puf2usrp.sv
// Scoreboard bench for puf2usrp: directed vectors push hand-computed outputs into a queue,
// a negedge monitor pops and compares on every output handshake.
module tb_puf2usrp;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset_n = 1'b1;
    logic           in_tvalid = 1'b0;
    logic           in_tready;
    logic           in_tlast = 1'b0;
    logic [2*W-1:0] in_tdata = '0;
    logic           out_tvalid;
    logic           out_tready = 1'b1;
    logic           out_tlast;
    logic [2*W-1:0] out_tdata;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [2*W:0] exp_q[$];

    // Latency probe: main arms it, send records the first accept, monitor measures once.
    logic lat_arm = 1'b0;
    logic lat_done = 1'b0;
    int   first_acc = -1;

    logic         prev_stall = 1'b0;
    logic [2*W:0] held = '0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    puf2usrp #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_tvalid (in_tvalid),
        .in_tready (in_tready),
        .in_tlast  (in_tlast),
        .in_tdata  (in_tdata),
        .out_tvalid(out_tvalid),
        .out_tready(out_tready),
        .out_tlast (out_tlast),
        .out_tdata (out_tdata)
    );

    function automatic logic [2*W-1:0] pk(input int i, input int q);
        logic [W-1:0] a, b;
        a = W'(i);
        b = W'(q);
        return {a, b};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input int i, input int q, input bit last);
        exp_q.push_back({last, pk(i, q)});
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input int i, input int q, input bit last);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        in_tdata  = pk(i, q);
        in_tlast  = last;
        in_tvalid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_tready;
            if (acc && lat_arm && first_acc < 0) first_acc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: beat %0d/%0d not accepted", i, q);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Monitor: handshake rule, stall hold, latency probe, scoreboard pop.
    always @(negedge clk) begin
        logic         stall;
        logic [2*W:0] e;
        if (reset_n) begin
            stall = out_tvalid && !out_tready;
            check("in_tready", 64'(in_tready), 64'(!stall));
            if (prev_stall) begin
                check("hold_valid", 64'(out_tvalid), 64'd1);
                check("hold_data", 64'({out_tlast, out_tdata}), 64'(held));
            end
            prev_stall <= stall;
            held <= {out_tlast, out_tdata};
            if (out_tvalid && lat_arm && !lat_done && first_acc >= 0) begin
                check("latency", 64'(cyc - first_acc), 64'd2);
                lat_done <= 1'b1;
            end
            if (out_tvalid && out_tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_output: got %0h expected none", {out_tlast, out_tdata});
                end else begin
                    e = exp_q.pop_front();
                    check("out", 64'({out_tlast, out_tdata}), 64'(e));
                end
            end
        end else begin
            prev_stall <= 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rx[20] = '{0, 1, 2, 0, 0, 0, -1, -2, 0, 0, 0, 0, 1, 2, 0, 0, 0, -1, -2, 0};
        int ry[16] = '{0, 1, 1, 0, 0, -1, -1, 0, 0, 0, 2, 1, 0, 0, -1, 0};

        // Reset state, asserted asynchronously between edges.
        #2 reset_n = 1'b0;
        #1;
        check("rst_valid", 64'(out_tvalid), 64'd0);
        check("rst_last", 64'(out_tlast), 64'd0);
        check("rst_data", 64'(out_tdata), 64'd0);
        check("rst_ready", 64'(in_tready), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Ramp, continuous ready, with first-output latency.
        lat_arm = 1'b1;
        for (int k = 0; k < 8; k++) push(125 * k, -125 * k, 1'b0);
        for (int k = 0; k < 10; k++) send(100 * k, -100 * k, 1'b0);
        drain("ramp_count");
        check("latency_seen", 64'(lat_done), 64'd1);
        lat_arm = 1'b0;

        // Rounding groups (I = Q).
        for (int k = 0; k < 16; k++) push(ry[k], ry[k], 1'b0);
        for (int k = 0; k < 20; k++) send(rx[k], rx[k], 1'b0);
        drain("round_count");

        // Saturation extremes.
        for (int k = 0; k < 4; k++) push(32767, -32768, 1'b0);
        for (int k = 0; k < 5; k++) send(32767, -32768, 1'b0);
        drain("sat_count");

        // tlast at phase 1, then a fresh packet starting at phase 0.
        push(10, -10, 1'b0);
        push(20, -20, 1'b1);
        push(0, 0, 1'b0);
        push(125, -125, 1'b0);
        push(250, -250, 1'b0);
        push(375, -375, 1'b0);
        send(10, -10, 1'b0);
        send(20, -20, 1'b1);
        for (int k = 0; k < 5; k++) send(100 * k, -100 * k, 1'b0);
        drain("tlast_count");

        // Backpressure: 5-cycle stall mid-stream, then random ready.
        for (int k = 0; k < 16; k++) push(125 * k, -125 * k, 1'b0);
        fork
            begin
                for (int k = 0; k < 20; k++) send(100 * k, -100 * k, 1'b0);
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_tready = 1'b0;
                repeat (5) @(posedge clk);
                for (int k = 0; k < 40; k++) begin
                    #1 out_tready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                end
                #1 out_tready = 1'b1;
            end
        join
        drain("bp_count");

        // Async reset with two outputs in flight (phase-2 result in S2, phase-3 in S1).
        push(1000, 0, 1'b0);
        send(1000, 0, 1'b0);
        send(2000, 0, 1'b0);
        send(3000, 0, 1'b0);
        send(4000, 0, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_tvalid), 64'd0);
        check("mid_rst_last", 64'(out_tlast), 64'd0);
        check("mid_rst_data", 64'(out_tdata), 64'd0);
        check("mid_rst_ready", 64'(in_tready), 64'd0);
        check("pre_rst_popped", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        push(777, 7, 1'b0);
        push(888, 8, 1'b1);
        send(777, 7, 1'b0);
        send(888, 8, 1'b1);
        drain("post_rst_count");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
